// File: rtl/nor_chain_pkg.sv
// Shared types and sizing for the NOR-chain sweeper and its golden model.
package nor_chain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned VEC_W   = 4;
    localparam int unsigned ERR_W   = 5;

endpackage

// File: rtl/nor_chain_golden.sv
// Reference behaviour of the cascaded NOR stage: e = ~(a|b), f = ~(e|c), g = ~(f|d).
module nor_chain_golden (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic exp_e,
    output logic exp_f,
    output logic exp_g
);

    always_comb begin
        exp_e = ~(a | b);
        exp_f = ~(exp_e | c);
        exp_g = ~(exp_f | d);
    end

endmodule

// File: rtl/nor_chain_sweeper.sv
// Drives all 16 input vectors into a NOR-chain stage, samples its outputs after a
// settle time and checks them against the golden model, reporting a summary.
module nor_chain_sweeper
    import nor_chain_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       d_o,
    input  logic       e_i,
    input  logic       f_i,
    input  logic       g_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    generate
        if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 15) begin : g_settle_range
            $error("nor_chain_sweeper: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q;
    logic [3:0]       cnt_q;
    logic [ERR_W-1:0] err_q;
    logic [VEC_W-1:0] ff_vec_q;
    logic             ff_valid_q;

    logic launch, settle_step, sample_now;
    logic exp_e, exp_f, exp_g;
    logic mismatch;

    nor_chain_golden u_golden (
        .a     (vec_q[3]),
        .b     (vec_q[2]),
        .c     (vec_q[1]),
        .d     (vec_q[0]),
        .exp_e (exp_e),
        .exp_f (exp_f),
        .exp_g (exp_g)
    );

    assign mismatch = ({e_i, f_i, g_i} != {exp_e, exp_f, exp_g});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        settle_step = 1'b0;
        sample_now  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                settle_step = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_now = 1'b1;
                state_d    = (vec_q == LAST_VEC) ? DONE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // vec only moves on edges entering SETTLE, so the stimulus pins are taken from it directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else if (launch) begin
            vec_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else if (settle_step) begin
            cnt_q <= cnt_q + 4'd1;
        end else if (sample_now) begin
            if (mismatch) begin
                err_q <= err_q + ERR_W'(1);
                if (!ff_valid_q) begin
                    ff_vec_q   <= vec_q;
                    ff_valid_q <= 1'b1;
                end
            end
            if (vec_q != LAST_VEC) begin
                vec_q <= vec_q + VEC_W'(1);
                cnt_q <= '0;
            end
        end
    end

    assign {a_o, b_o, c_o, d_o} = vec_q;
    assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done             = (state_q == DONE);
    assign pass             = done && (err_q == '0);
    assign err_cnt          = err_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_nor_chain_sweeper.sv
// Bench for nor_chain_sweeper: two builds (settle 2 and 1) against a modelled NOR stage
// with selectable faults, checked every cycle plus pinned literal results.
module tb_nor_chain_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    int   mode = 0; // 0 correct stage, 1 g stuck 0, 2 e stuck 1

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT 0 : default settle (2) ----------------
    logic a0, b0, c0, d0, e0, f0, g0;
    logic busy0, done0, pass0, ffvalid0;
    logic [4:0] err0;
    logic [3:0] ffvec0;

    assign e0 = (mode == 2) ? 1'b1 : ~(a0 | b0);
    assign f0 = ~(~(a0 | b0) | c0);
    assign g0 = (mode == 1) ? 1'b0 : ~(f0 | d0);

    nor_chain_sweeper #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0),
        .e_i(e0), .f_i(f0), .g_i(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_fail_vec(ffvec0), .first_fail_valid(ffvalid0)
    );

    // ---------------- DUT 1 : settle 1 ----------------
    logic a1, b1, c1, d1, e1, f1, g1;
    logic busy1, done1, pass1, ffvalid1;
    logic [4:0] err1;
    logic [3:0] ffvec1;

    assign e1 = (mode == 2) ? 1'b1 : ~(a1 | b1);
    assign f1 = ~(~(a1 | b1) | c1);
    assign g1 = (mode == 1) ? 1'b0 : ~(f1 | d1);

    nor_chain_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
        .e_i(e1), .f_i(f1), .g_i(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_fail_vec(ffvec1), .first_fail_valid(ffvalid1)
    );

    logic [16:0] act0, act1;
    assign act0 = {a0, b0, c0, d0, busy0, done0, pass0, err0, ffvec0, ffvalid0};
    assign act1 = {a1, b1, c1, d1, busy1, done1, pass1, err1, ffvec1, ffvalid1};

    // ---------------- behavioural model ----------------
    function automatic bit vec_fails(input int k, input int m);
        bit a, b, c, d, e, f, g, eo, fo, go;
        a = k[3]; b = k[2]; c = k[1]; d = k[0];
        e = !(a || b);
        f = !(e || c);
        g = !(f || d);
        eo = (m == 2) ? 1'b1 : e;
        fo = f;
        go = (m == 1) ? 1'b0 : g;
        return {eo, fo, go} != {e, f, g};
    endfunction

    // n = clock edges since the edge that accepted start; p = cycles per vector
    function automatic logic [16:0] expect_out(input bit act, input int n, input int p, input int m);
        int  total, vec, n_done, errs, ffv;
        bit  bsy, dn, ffok;
        if (!act) return '0;
        total = 16 * p;
        if (n < total) begin
            vec = n / p; bsy = 1'b1; dn = 1'b0; n_done = n / p;
        end else begin
            vec = 15; bsy = 1'b0; dn = 1'b1; n_done = 16;
        end
        errs = 0; ffv = 0; ffok = 1'b0;
        for (int k = 0; k < n_done; k++) begin
            if (vec_fails(k, m)) begin
                if (!ffok) begin
                    ffv  = k;
                    ffok = 1'b1;
                end
                errs++;
            end
        end
        return {4'(vec), bsy, dn, (dn && errs == 0), 5'(errs), 4'(ffv), ffok};
    endfunction

    bit m_act0 = 1'b0, m_act1 = 1'b0;
    int m_n0 = 0, m_n1 = 0, m_md0 = 0, m_md1 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act0 <= 1'b0; m_n0 <= 0;
        end else if (start && (!m_act0 || m_n0 >= 48)) begin
            m_act0 <= 1'b1; m_n0 <= 0; m_md0 <= mode;
        end else if (m_act0 && m_n0 < 48) begin
            m_n0 <= m_n0 + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act1 <= 1'b0; m_n1 <= 0;
        end else if (start && (!m_act1 || m_n1 >= 32)) begin
            m_act1 <= 1'b1; m_n1 <= 0; m_md1 <= mode;
        end else if (m_act1 && m_n1 < 32) begin
            m_n1 <= m_n1 + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [16:0] w0, w1;
        if (chk_en) begin
            w0 = expect_out(m_act0, m_n0, 3, m_md0);
            w1 = expect_out(m_act1, m_n1, 2, m_md1);
            n_cmp++;
            if (act0 !== w0) begin
                n_bad++;
                $display("FAIL cycle_dut0 t=%0t got=%h expected=%h", $time, act0, w0);
            end
            n_cmp++;
            if (act1 !== w1) begin
                n_bad++;
                $display("FAIL cycle_dut1 t=%0t got=%h expected=%h", $time, act1, w1);
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic run_sweep(input int m, input int e_err, input int e_ff, input bit e_ffv);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_lit("busy_after_start", 32'(busy0), 32'd1);
        repeat (47) @(posedge clk);
        #1;
        check_lit("not_done_edge47", 32'(done0), 32'd0);
        @(posedge clk); #1;
        check_lit("done0", 32'(done0), 32'd1);
        check_lit("busy0_low", 32'(busy0), 32'd0);
        check_lit("pass0", 32'(pass0), 32'(e_err == 0));
        check_lit("err_cnt0", 32'(err0), 32'(e_err));
        check_lit("ff_vec0", 32'(ffvec0), 32'(e_ff));
        check_lit("ff_valid0", 32'(ffvalid0), 32'(e_ffv));
        check_lit("done1", 32'(done1), 32'd1);
        check_lit("err_cnt1", 32'(err1), 32'(e_err));
        check_lit("ff_vec1", 32'(ffvec1), 32'(e_ff));
        check_lit("ff_valid1", 32'(ffvalid1), 32'(e_ffv));
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_outputs0", 32'(act0), 32'd0);
        check_lit("reset_outputs1", 32'(act1), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_sweep(0, 0, 0, 1'b0);
        run_sweep(1, 5, 0, 1'b1);
        run_sweep(2, 12, 4, 1'b1);

        // reset in the middle of a sweep, then a fresh sweep
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_lit("midsweep_reset0", 32'(act0), 32'd0);
        check_lit("midsweep_reset1", 32'(act1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 0, 0, 1'b0);

        // start held high across the sweep, then a restart from DONE
        @(negedge clk);
        mode  = 1;
        start = 1'b1;
        @(posedge clk);
        repeat (47) @(posedge clk);
        #1;
        start = 1'b0;
        check_lit("held_start_vec15", 32'({a0, b0, c0, d0}), 32'hf);
        check_lit("held_start_busy", 32'(busy0), 32'd1);
        check_lit("held_start_not_done", 32'(done0), 32'd0);
        @(posedge clk); #1;
        check_lit("held_start_done", 32'(done0), 32'd1);
        check_lit("held_start_err", 32'(err0), 32'd5);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_lit("restart_err_clr", 32'(err0), 32'd0);
        check_lit("restart_ffvalid_clr", 32'(ffvalid0), 32'd0);
        check_lit("restart_busy", 32'(busy0), 32'd1);
        check_lit("restart_done_clr", 32'(done0), 32'd0);
        repeat (48) @(posedge clk);
        #1;
        check_lit("restart_done", 32'(done0), 32'd1);
        check_lit("restart_err", 32'(err0), 32'd5);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
